// File: rtl/piso_out_ctrl_if.sv
// Frame-side and byte-side handshake bundle for the output PISO sequencer.
// The slave modport is the controller; the master modport is its upstream/downstream.
interface piso_out_ctrl_if;
   logic       frame_valid;
   logic       frame_ready;
   logic [2:0] frame_len_m1;
   logic       abort;
   logic       byte_valid;
   logic       byte_ready;
   logic       byte_last;

   modport master (
      output frame_valid, frame_len_m1, abort, byte_ready,
      input  frame_ready, byte_valid, byte_last
   );

   modport slave (
      input  frame_valid, frame_len_m1, abort, byte_ready,
      output frame_ready, byte_valid, byte_last
   );
endinterface

// File: rtl/piso_out_ctrl.sv
// Sequencer for the 8-byte output PISO: loads a frame, streams 1-8 bytes under
// valid/ready, supports abort, and counts completed frames.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no frame held; frame_ready offered unless abort
//   SEND  | PISO data_out holds byte cnt of a frame of len+1 bytes
module piso_out_ctrl #(
   parameter int CNT_W       = 16,
   parameter bit CLR_ON_DONE = 1'b1
) (
   input  logic             CLKEXT,
   input  logic             CLR_N,
   piso_out_ctrl_if.slave   bus,
   output logic             EN_PISO_OUT,
   output logic             SHIFT_OUT,
   output logic             CLR_PISO_OUT,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t     state;
   logic [2:0] cnt;
   logic [2:0] len;
   logic       load;
   logic       xfer;
   logic       last;

   // Handshakes are decoded combinationally so the PISO acts on the same edge.
   always_comb begin
      bus.frame_ready = CLR_N & (state == IDLE) & ~bus.abort;
      bus.byte_valid  = CLR_N & (state == SEND) & ~bus.abort;
      last            = (cnt == len);
      bus.byte_last   = bus.byte_valid & last;
      busy            = (state == SEND);
      load            = bus.frame_valid & bus.frame_ready;
      xfer            = bus.byte_valid & bus.byte_ready;
      EN_PISO_OUT     = load | (xfer & ~last);
      SHIFT_OUT       = xfer & ~last;
      CLR_PISO_OUT    = ~CLR_N
                      | ((state == SEND) & bus.abort)
                      | (xfer & last & CLR_ON_DONE);
   end

   always_ff @(posedge CLKEXT) begin
      if (!CLR_N) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         len       <= 3'd0;
         frame_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  len   <= bus.frame_len_m1;
                  cnt   <= 3'd0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (bus.abort) begin
                  state <= IDLE;
               end else if (xfer) begin
                  if (last) begin
                     frame_cnt <= frame_cnt + CNT_W'(1);
                     state     <= IDLE;
                  end else begin
                     cnt <= cnt + 3'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/piso_out_ctrl.md
Name: piso_out_ctrl

Overview:
- Sequencer for the 8-byte output PISO shifter. It accepts one frame at a time from the upstream result stage and drives the PISO's EN_PISO_OUT, SHIFT_OUT and CLR_PISO_OUT.
- It presents the PISO's data_out byte to the downstream consumer under a valid/ready handshake, one byte per accepted transfer, with byte_last on the final byte.
- It supports variable frame length (1-8 bytes), abort, and a completed-frame counter.

Parameters:
- CNT_W, 16, width of the completed-frame counter frame_cnt.
- CLR_ON_DONE, 1, 1 = pulse CLR_PISO_OUT on the last-byte handshake; 0 = leave the PISO contents untouched after a frame.

Ports:
- CLKEXT  in  1  single clock, all logic on its rising edge.
- CLR_N  in  1  synchronous active-low reset.
- frame_valid  in  1  upstream has 8 bytes on the PISO data_0..data_7 inputs.
- frame_ready  out  1  controller can load a frame this cycle.
- frame_len_m1  in  3  number of bytes to send minus 1. Sampled on frame handshake.
- abort  in  1  drop the current frame immediately.
- EN_PISO_OUT  out  1  PISO enable.
- SHIFT_OUT  out  1  PISO shift (1) / load (0) select.
- CLR_PISO_OUT  out  1  PISO synchronous clear, active high.
- byte_valid  out  1  PISO data_out holds a byte for downstream.
- byte_ready  in  1  downstream accepts the byte.
- byte_last  out  1  current byte is the last of the frame.
- busy  out  1  frame in progress.
- frame_cnt  out  CNT_W  frames completed (last byte accepted), not aborted.

Behaviour:
- Clock CLKEXT, reset CLR_N: one clock, synchronous, active-low.
- Reset, CLR_N=0 at an edge:
  - state<=IDLE, byte counter<=0, latched length<=0, frame_cnt<=0.
  - CLR_PISO_OUT=1 combinationally whenever CLR_N=0, so the PISO clears on the same edge.
  - EN_PISO_OUT=0, SHIFT_OUT=0, byte_valid=0, frame_ready=0 while CLR_N=0.
- Reset mid-frame discards the frame: no byte_last, no count.
- States: IDLE, SEND.
- Handshake outputs are combinational from state and inputs. They are decoded as follows:
  - frame_ready = (state==IDLE) & ~abort.
  - byte_valid = (state==SEND) & ~abort.
  - byte_last = byte_valid & (cnt==len).
  - busy = (state==SEND).
- IDLE:
  - On frame_valid & frame_ready: EN_PISO_OUT=1, SHIFT_OUT=0 that cycle, so the PISO loads data_0..7 on this edge.
  - On the same frame handshake, latch len<=frame_len_m1, cnt<=0, state<=SEND.
  - Load-to-first-byte latency: exactly 1 cycle.
- SEND, byte_valid & byte_ready & ~byte_last:
  - EN_PISO_OUT=1, SHIFT_OUT=1 that cycle; cnt<=cnt+1.
  - The next byte appears on data_out the following cycle, so there is no bubble under continuous ready.
- SEND, byte_valid & byte_ready & byte_last:
  - No shift.
  - CLR_PISO_OUT=CLR_ON_DONE that cycle.
  - frame_cnt<=frame_cnt+1, wrapping modulo 2^CNT_W.
  - state<=IDLE.
  - The next frame can be loaded the cycle after, giving a minimum frame period of len+2 cycles.
- SEND, byte_valid & ~byte_ready (backpressure): EN_PISO_OUT=0; PISO, cnt and state hold indefinitely.
- abort=1 in SEND:
  - byte_valid forced 0, so any byte_ready that cycle is not a transfer.
  - CLR_PISO_OUT=1, state<=IDLE, no count increment.
  - Abort takes priority over everything except reset.
- abort=1 in IDLE: frame_ready=0, so no load occurs. CLR_PISO_OUT=0 and state is unchanged.
- EN_PISO_OUT and CLR_PISO_OUT are never both 1 in the same cycle.
- The PISO shifts zeros in, so at most 8 bytes are meaningful. frame_len_m1=7 sends all eight.
- frame_valid while busy is ignored and must be held by upstream until frame_ready.

Test Plan:
1. Reset, then frame 0x11..0x88 with frame_len_m1=7 and byte_ready=1 constantly:
   - Load at cycle 0.
   - byte_valid on cycles 1-8 with data_out 0x11,0x22,...,0x88.
   - SHIFT_OUT pulses on cycles 1-7.
   - byte_last and CLR_PISO_OUT on cycle 8.
   - frame_cnt=1; frame_ready=1 on cycle 9.
2. Same frame with byte_ready toggling 1,0,0,1,...:
   - Bytes are delivered in order with no duplication or loss.
   - EN_PISO_OUT=0 on every stalled cycle.
3. frame_len_m1=0:
   - Single byte 0x11 with byte_last on cycle 1.
   - No SHIFT_OUT; frame_cnt increments.
4. Abort during the 4th byte:
   - byte_valid=0 that cycle, CLR_PISO_OUT=1, IDLE next cycle, frame_cnt unchanged.
   - Next frame sends 0x11 first.
5. CLR_N=0 for one cycle mid-frame:
   - All outputs return to reset values and frame_cnt=0.
   - The PISO is cleared.
   - A fresh frame then completes normally.
6. CNT_W=2 with five back-to-back frames:
   - frame_cnt reads 1,2,3,0,1.
   - CLR_ON_DONE=0 variant: no CLR_PISO_OUT pulse at frame end.
